// File: rtl/router_port_requester.sv
// router_port_requester: per-port client of the router's fixed-priority arbiter.
// Requests the crossbar for each buffered packet, streams it while granted, then yields.
module router_port_requester #(
    parameter int DATA_W     = 32,
    parameter int MAX_LEN    = 16,
    parameter int WAIT_MAX   = 64,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] pkt_data,
    input  logic              pkt_last,
    output logic              pkt_ready,
    output logic              request,
    input  logic              grant,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              starve,
    output logic              len_err,
    output logic [7:0]        preempt_cnt
);

    // state | meaning
    // IDLE  | no packet pending, request low
    // REQ   | packet waiting upstream, request high, awaiting grant
    // XFER  | granted; beats move when grant, pkt_valid and out_ready are all high
    // DROP  | packet truncated; remaining beats discarded with request low
    // GAP   | request held low so the arbiter re-arbitrates
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_XFER = 3'd2,
        S_DROP = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam int BEAT_W = $clog2(MAX_LEN + 1);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t              state_q, state_d;
    logic                request_q, request_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                starve_q, starve_d;
    logic                len_err_q, len_err_d;
    logic [7:0]          preempt_cnt_q, preempt_cnt_d;
    logic                grant_prev_q, grant_prev_d;

    logic in_xfer;
    logic fire;
    logic force_last;

    assign in_xfer    = (state_q == S_XFER);
    assign fire       = in_xfer & grant & pkt_valid & out_ready;
    assign force_last = in_xfer & (beat_cnt_q == BEAT_W'(MAX_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            request_q     <= 1'b0;
            beat_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            starve_q      <= 1'b0;
            len_err_q     <= 1'b0;
            preempt_cnt_q <= '0;
            grant_prev_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            request_q     <= request_d;
            beat_cnt_q    <= beat_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            starve_q      <= starve_d;
            len_err_q     <= len_err_d;
            preempt_cnt_q <= preempt_cnt_d;
            grant_prev_q  <= grant_prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (pkt_valid) state_d = S_REQ;
            S_REQ:  if (grant) state_d = S_XFER;
            S_XFER: begin
                if (fire) begin
                    if (pkt_last)        state_d = S_GAP;
                    else if (force_last) state_d = S_DROP;
                end
            end
            S_DROP: if (pkt_valid & pkt_last) state_d = S_GAP;
            S_GAP:  if (gap_cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        request_d     = (state_d == S_REQ) || (state_d == S_XFER);
        beat_cnt_d    = beat_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        starve_d      = starve_q;
        len_err_d     = len_err_q;
        preempt_cnt_d = preempt_cnt_q;
        grant_prev_d  = grant;

        if (state_q == S_REQ) begin
            if (grant) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != WAIT_W'(WAIT_MAX)) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (wait_cnt_q == WAIT_W'(WAIT_MAX - 1)) starve_d = 1'b1;
            end
        end

        if (fire) begin
            starve_d   = 1'b0;
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            if (!pkt_last && force_last) len_err_d = 1'b1;
        end

        // a grant falling edge while streaming is a preemption
        if (in_xfer && grant_prev_q && !grant && (preempt_cnt_q != 8'hFF))
            preempt_cnt_d = preempt_cnt_q + 8'd1;

        if ((state_d == S_GAP) && (state_q != S_GAP)) begin
            beat_cnt_d = '0;
            gap_cnt_d  = GAP_W'(GAP_CYCLES - 1);
        end else if ((state_q == S_GAP) && (gap_cnt_q != '0)) begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
    end

    always_comb begin
        out_valid = in_xfer & grant & pkt_valid;
        pkt_ready = (in_xfer & grant & out_ready) | (state_q == S_DROP);
        out_last  = (pkt_last | force_last) & out_valid;
    end

    assign out_data    = pkt_data;
    assign request     = request_q;
    assign starve      = starve_q;
    assign len_err     = len_err_q;
    assign preempt_cnt = preempt_cnt_q;

endmodule

// File: tb/tb_router_port_requester.sv
// Bench for router_port_requester: directed scenarios plus randomized packet traffic
// checked against a packet-level reference of what the crossbar and flags should see.
module tb_router_port_requester;

    localparam int DATA_W     = 32;
    localparam int MAX_LEN    = 16;
    localparam int WAIT_MAX   = 64;
    localparam int GAP_CYCLES = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              pkt_valid;
    logic [DATA_W-1:0] pkt_data;
    logic              pkt_last;
    logic              pkt_ready;
    logic              request;
    logic              grant;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic              starve;
    logic              len_err;
    logic [7:0]        preempt_cnt;

    router_port_requester #(
        .DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .WAIT_MAX(WAIT_MAX), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_last(pkt_last), .pkt_ready(pkt_ready),
        .request(request), .grant(grant),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .starve(starve), .len_err(len_err), .preempt_cnt(preempt_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] up_data[$];
    logic              up_last[$];
    int                up_idx[$];
    logic [DATA_W-1:0] exp_data[$];
    logic              exp_last[$];
    logic              exp_trunc[$];

    int   vprob, rprob, gprob, gmode;
    logic req_prev, grant_prev, seen_req, granted_seen, end_prev;
    int   low_run, wait_exp, fire_total;
    logic starve_exp, len_err_exp;
    int   preempt_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_pkt(input int len);
        for (int i = 0; i < len; i++) begin
            logic [DATA_W-1:0] d;
            d = $urandom;
            up_data.push_back(d);
            up_last.push_back(i == len - 1);
            up_idx.push_back(i);
            if (i < MAX_LEN) begin
                exp_data.push_back(d);
                exp_last.push_back((i == len - 1) || (i == MAX_LEN - 1));
                exp_trunc.push_back((i == MAX_LEN - 1) && (len > MAX_LEN));
            end
        end
    endtask

    task automatic drive();
        pkt_valid = (up_data.size() > 0) && ($urandom_range(99) < vprob);
        if (up_data.size() > 0) begin
            pkt_data = up_data[0];
            pkt_last = up_last[0];
        end else begin
            pkt_data = '0;
            pkt_last = 1'b0;
        end
        out_ready = ($urandom_range(99) < rprob);
        grant     = (gmode == 0) ? ($urandom_range(99) < gprob) : (gmode == 2);
    endtask

    task automatic observe();
        logic fire, take;
        fire = out_valid && out_ready;
        take = pkt_valid && pkt_ready;

        chk("starve", starve, starve_exp);
        chk("len_err", len_err, len_err_exp);
        chk("preempt_cnt", preempt_cnt, preempt_exp);
        if (end_prev) chk("req_after_pkt_end", request, 0);
        if (request && !req_prev && seen_req) chk("req_gap_len", low_run >= GAP_CYCLES, 1);
        if (!(request && grant && pkt_valid)) chk("out_valid_gate", out_valid, 0);
        if (request) chk("up_down_fire_pair", take, fire);
        if (out_valid) chk("out_data_pass", out_data, pkt_data);
        end_prev = 1'b0;

        if (request && granted_seen && grant_prev && !grant && preempt_exp < 255) preempt_exp++;
        if (!request) begin
            granted_seen = 1'b0;
            wait_exp     = 0;
        end else if (!granted_seen) begin
            if (grant) granted_seen = 1'b1;
            else begin
                wait_exp++;
                if (wait_exp >= WAIT_MAX) starve_exp = 1'b1;
            end
        end

        if (fire) begin
            fire_total++;
            starve_exp = 1'b0;
            if (exp_data.size() == 0) chk("sb_underflow", exp_data.size(), 1);
            else begin
                chk("out_beat_data", out_data, exp_data[0]);
                chk("out_beat_last", out_last, exp_last[0]);
                if (exp_trunc[0]) len_err_exp = 1'b1;
                if (out_last) end_prev = 1'b1;
                void'(exp_data.pop_front());
                void'(exp_last.pop_front());
                void'(exp_trunc.pop_front());
            end
        end

        if (take) begin
            if (up_data.size() == 0) chk("up_underflow", up_data.size(), 1);
            else begin
                if (up_idx[0] >= MAX_LEN) begin
                    chk("drop_request", request, 0);
                    chk("drop_out_valid", out_valid, 0);
                    if (up_last[0]) end_prev = 1'b1;
                end
                void'(up_data.pop_front());
                void'(up_last.pop_front());
                void'(up_idx.pop_front());
            end
        end

        if (request) begin
            low_run  = 0;
            seen_req = 1'b1;
        end else begin
            low_run++;
        end
        req_prev   = request;
        grant_prev = grant;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk("rst_request", request, 0);
        chk("rst_out_valid", out_valid, 0);
        pkt_valid = 1'b0; pkt_last = 1'b0; pkt_data = '0; grant = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_pkt_ready", pkt_ready, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_starve", starve, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_preempt_cnt", preempt_cnt, 0);
        up_data.delete(); up_last.delete(); up_idx.delete();
        exp_data.delete(); exp_last.delete(); exp_trunc.delete();
        starve_exp = 1'b0; len_err_exp = 1'b0; preempt_exp = 0;
        req_prev = 1'b0; grant_prev = 1'b0; seen_req = 1'b0; granted_seen = 1'b0;
        end_prev = 1'b0; low_run = 0; wait_exp = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((up_data.size() + exp_data.size()) > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_complete", up_data.size() + exp_data.size(), 0);
        repeat (GAP_CYCLES + 2) step();
    endtask

    task automatic wait_fires(input int target, input int budget);
        int n;
        n = 0;
        while (fire_total < target && n < budget) begin
            step();
            n++;
        end
        chk("fire_wait", fire_total >= target, 1);
    endtask

    initial begin
        reset = 1'b0; pkt_valid = 1'b0; pkt_data = '0; pkt_last = 1'b0;
        grant = 1'b0; out_ready = 1'b0;
        vprob = 100; rprob = 100; gprob = 100; gmode = 1; fire_total = 0;
        #2;
        apply_reset();

        // single 3-beat packet, grant two cycles after request
        add_pkt(3);
        step();
        chk("req_latency_lo", request, 0);
        step();
        chk("req_latency_hi", request, 1);
        repeat (2) step();
        gmode = 2;
        drain(50);

        // grant withheld long enough to starve
        add_pkt(4);
        gmode = 1;
        repeat (70) step();
        chk("starve_set", starve, 1);
        gmode = 2;
        drain(50);
        chk("starve_cleared", starve, 0);
        chk("no_preempt_yet", preempt_cnt, 0);

        // over-length packet truncated and the tail dropped
        add_pkt(20);
        drain(100);
        chk("len_err_sticky", len_err, 1);

        // grant removed for 5 cycles after beat 2 of 6
        add_pkt(6);
        wait_fires(fire_total + 2, 50);
        gmode = 1;
        repeat (5) begin
            step();
            chk("stall_out_valid", out_valid, 0);
            chk("stall_request", request, 1);
        end
        gmode = 2;
        drain(50);
        chk("preempt_once", preempt_cnt, 1);

        // reset in the middle of a packet, then a clean packet
        add_pkt(8);
        wait_fires(fire_total + 3, 50);
        #2;
        apply_reset();
        add_pkt(5);
        drain(60);

        // randomized back-to-back traffic
        for (int r = 0; r < 6; r++) begin
            vprob = $urandom_range(100, 50);
            rprob = (r % 2 == 0) ? 50 : $urandom_range(100, 40);
            gprob = $urandom_range(100, 40);
            gmode = 0;
            for (int p = 0; p < 5; p++) add_pkt($urandom_range(22, 1));
            drain(6000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
